// File: rtl/gamma_pkg.sv
// Shared definitions for the multi-channel gamma generator: combine modes,
// default feedback mask and the Galois LFSR step function.
package gamma_pkg;

  typedef enum logic [1:0] {
    GM_XOR    = 2'b00,
    GM_ADD    = 2'b01,
    GM_SUB    = 2'b10,
    GM_BYPASS = 2'b11
  } gm_mode_e;

  localparam int unsigned LFSR_MAX_W = 64;
  localparam logic [7:0]  DEFAULT_TAPS = 8'hB8;

  // Callers zero-extend narrower states; zero upper bits keep the shift exact.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_step(
    input logic [LFSR_MAX_W-1:0] s,
    input logic [LFSR_MAX_W-1:0] taps
  );
    return (s >> 1) ^ (s[0] ? taps : '0);
  endfunction

endpackage

// File: rtl/gamma_lfsr.sv
// One gamma channel: Galois LFSR state plus a flag recording whether it has
// ever been seeded. A load takes priority over an advance in the same cycle.
module gamma_lfsr
  import gamma_pkg::*;
#(
  parameter int unsigned     WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEFAULT_TAPS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             advance,
  output logic [WIDTH-1:0] state,
  output logic             seeded
);

  logic [WIDTH-1:0] state_next;
  logic [WIDTH-1:0] seed_safe;

  always_comb begin
    state_next = WIDTH'(lfsr_step(LFSR_MAX_W'(state), LFSR_MAX_W'(TAPS)));
    // An all-zero state would lock the LFSR, so a zero seed becomes all-ones.
    seed_safe  = (seed == '0) ? '1 : seed;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= '0;
      seeded <= 1'b0;
    end else if (load) begin
      state  <= seed_safe;
      seeded <= 1'b1;
    end else if (advance && seeded) begin
      state  <= state_next;
    end
  end

endmodule

// File: rtl/gen_gamma_stream.sv
// Multi-channel gamma combiner: per-channel LFSRs, channel mux, XOR/add/sub/
// bypass combiner and a registered valid/ready output stage.
module gen_gamma_stream
  import gamma_pkg::*;
#(
  parameter int unsigned      WIDTH    = 8,
  parameter int unsigned      CHANNELS = 4,
  parameter logic [WIDTH-1:0] TAPS     = WIDTH'(DEFAULT_TAPS),
  localparam int unsigned     CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                seed_we,
  input  logic [CH_W-1:0]     seed_ch,
  input  logic [WIDTH-1:0]    seed,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CH_W-1:0]     in_ch,
  input  logic [1:0]          in_mode,
  input  logic [WIDTH-1:0]    in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CH_W-1:0]     out_ch,
  output logic [WIDTH-1:0]    out_data,
  output logic                out_carry,
  output logic                out_err,
  output logic [CHANNELS-1:0] seeded
);

  logic [WIDTH-1:0]    states [CHANNELS];
  logic [CHANNELS-1:0] load;
  logic [CHANNELS-1:0] advance;

  logic                accept;
  logic                in_range;
  logic                sel_seeded;
  logic [WIDTH-1:0]    gamma;
  gm_mode_e            mode;
  logic [WIDTH-1:0]    res_data;
  logic                res_carry;
  logic                res_err;
  logic                do_step;
  logic [WIDTH:0]      sum;
  logic [WIDTH:0]      diff;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign mode     = gm_mode_e'(in_mode);
  assign in_range = int'(in_ch) < int'(CHANNELS);

  // Channel mux reads the pre-update state, so a same-cycle seed is not seen.
  always_comb begin
    gamma      = '0;
    sel_seeded = 1'b0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (in_ch == CH_W'(i)) begin
        gamma      = states[i];
        sel_seeded = seeded[i];
      end
    end
  end

  always_comb begin
    sum       = {1'b0, in_data} + {1'b0, gamma};
    diff      = {1'b0, in_data} - {1'b0, gamma};
    res_data  = in_data;
    res_carry = 1'b0;
    res_err   = 1'b0;
    do_step   = 1'b0;
    if (!in_range || !sel_seeded) begin
      res_err = 1'b1;
    end else begin
      unique case (mode)
        GM_XOR: begin
          res_data = in_data ^ gamma;
          do_step  = 1'b1;
        end
        GM_ADD: begin
          {res_carry, res_data} = sum;
          do_step               = 1'b1;
        end
        GM_SUB: begin
          res_data  = diff[WIDTH-1:0];
          res_carry = diff[WIDTH];
          do_step   = 1'b1;
        end
        GM_BYPASS: begin
          res_data = in_data;
        end
      endcase
    end
  end

  always_comb begin
    load    = '0;
    advance = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      load[i]    = seed_we && (seed_ch == CH_W'(i));
      advance[i] = accept && do_step && (in_ch == CH_W'(i));
    end
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    gamma_lfsr #(
      .WIDTH (WIDTH),
      .TAPS  (TAPS)
    ) u_lfsr (
      .clk     (clk),
      .rst     (rst),
      .load    (load[gi]),
      .seed    (seed),
      .advance (advance[gi]),
      .state   (states[gi]),
      .seeded  (seeded[gi])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_data  <= '0;
      out_carry <= 1'b0;
      out_err   <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_ch    <= in_ch;
      out_data  <= res_data;
      out_carry <= res_carry;
      out_err   <= res_err;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gen_gamma_stream.sv
// Directed bench for gen_gamma_stream: vector table for single-cycle beats,
// plus hand sequences for backpressure, same-cycle seeding and async reset.
module tb_gen_gamma_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic       seed_we;
  logic [1:0] seed_ch;
  logic [7:0] seed;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_ch;
  logic [1:0] in_mode;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_ch;
  logic [7:0] out_data;
  logic       out_carry;
  logic       out_err;
  logic [3:0] seeded;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  gen_gamma_stream #(
    .WIDTH    (8),
    .CHANNELS (4),
    .TAPS     (8'hB8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .seed_we   (seed_we),
    .seed_ch   (seed_ch),
    .seed      (seed),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ch     (in_ch),
    .in_mode   (in_mode),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch),
    .out_data  (out_data),
    .out_carry (out_carry),
    .out_err   (out_err),
    .seeded    (seeded)
  );

  typedef struct {
    logic       sw;
    logic [1:0] sch;
    logic [7:0] sd;
    logic       iv;
    logic [1:0] ich;
    logic [1:0] md;
    logic [7:0] dat;
    logic       ev;
    logic [1:0] ech;
    logic [7:0] ed;
    logic       ec;
    logic       ee;
    logic [3:0] es;
  } vec_t;

  localparam int NV = 13;
  vec_t vec [NV];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic sw, input logic [1:0] sch, input logic [7:0] sd,
                       input logic iv, input logic [1:0] ich, input logic [1:0] md,
                       input logic [7:0] dat, input logic ordy);
    seed_we   = sw;
    seed_ch   = sch;
    seed      = sd;
    in_valid  = iv;
    in_ch     = ich;
    in_mode   = md;
    in_data   = dat;
    out_ready = ordy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_beat(input string nm, input logic [7:0] ed, input logic ec, input logic ee);
    check({nm, ".valid"}, 32'(out_valid), 32'd1);
    check({nm, ".data"},  32'(out_data),  32'(ed));
    check({nm, ".carry"}, 32'(out_carry), 32'(ec));
    check({nm, ".err"},   32'(out_err),   32'(ee));
  endtask

  initial begin
    // sw sch sd | iv ich md dat | ev ech ed ec ee es
    vec[0]  = '{1'b1, 2'd0, 8'h01, 1'b0, 2'd0, 2'b00, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 4'b0001};
    vec[1]  = '{1'b1, 2'd1, 8'hF0, 1'b1, 2'd0, 2'b00, 8'hA5, 1'b1, 2'd0, 8'hA4, 1'b0, 1'b0, 4'b0011};
    vec[2]  = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 2'b00, 8'hA5, 1'b1, 2'd0, 8'h1D, 1'b0, 1'b0, 4'b0011};
    vec[3]  = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 2'b00, 8'h00, 1'b1, 2'd0, 8'h5C, 1'b0, 1'b0, 4'b0011};
    vec[4]  = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 2'b01, 8'h20, 1'b1, 2'd1, 8'h10, 1'b1, 1'b0, 4'b0011};
    vec[5]  = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 2'b10, 8'h10, 1'b1, 2'd1, 8'h98, 1'b1, 1'b0, 4'b0011};
    vec[6]  = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 2'b00, 8'h3C, 1'b1, 2'd2, 8'h3C, 1'b0, 1'b1, 4'b0011};
    vec[7]  = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 2'b01, 8'h3C, 1'b1, 2'd2, 8'h3C, 1'b0, 1'b1, 4'b0011};
    vec[8]  = '{1'b1, 2'd2, 8'h00, 1'b0, 2'd0, 2'b00, 8'h00, 1'b0, 2'd2, 8'h3C, 1'b0, 1'b1, 4'b0111};
    vec[9]  = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 2'b00, 8'h00, 1'b1, 2'd2, 8'hFF, 1'b0, 1'b0, 4'b0111};
    vec[10] = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 2'b11, 8'h55, 1'b1, 2'd2, 8'h55, 1'b0, 1'b0, 4'b0111};
    vec[11] = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 2'b00, 8'h00, 1'b1, 2'd2, 8'hC7, 1'b0, 1'b0, 4'b0111};
    vec[12] = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd3, 2'b10, 8'h01, 1'b1, 2'd3, 8'h01, 1'b0, 1'b1, 4'b0111};

    rst = 1'b1;
    drive(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 2'b00, 8'h00, 1'b1);
    step();
    step();
    check("reset.valid",  32'(out_valid), 32'd0);
    check("reset.data",   32'(out_data),  32'h0);
    check("reset.ch",     32'(out_ch),    32'd0);
    check("reset.carry",  32'(out_carry), 32'd0);
    check("reset.err",    32'(out_err),   32'd0);
    check("reset.seeded", 32'(seeded),    32'h0);
    rst = 1'b0;
    #1;
    check("reset.in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < NV; i++) begin
      drive(vec[i].sw, vec[i].sch, vec[i].sd, vec[i].iv, vec[i].ich, vec[i].md, vec[i].dat, 1'b1);
      step();
      check($sformatf("v%0d.valid", i),  32'(out_valid), 32'(vec[i].ev));
      check($sformatf("v%0d.ch", i),     32'(out_ch),    32'(vec[i].ech));
      check($sformatf("v%0d.data", i),   32'(out_data),  32'(vec[i].ed));
      check($sformatf("v%0d.carry", i),  32'(out_carry), 32'(vec[i].ec));
      check($sformatf("v%0d.err", i),    32'(out_err),   32'(vec[i].ee));
      check($sformatf("v%0d.seeded", i), 32'(seeded),    32'(vec[i].es));
      check($sformatf("v%0d.in_ready", i), 32'(in_ready), 32'd1);
    end

    // ch0 state is 2E here; 11^2E=3F, state then 17.
    drive(1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 2'b00, 8'h11, 1'b1);
    step();
    check_beat("bp.pre", 8'h3F, 1'b0, 1'b0);
    drive(1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 2'b00, 8'h00, 1'b0);
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("bp%0d.in_ready", k), 32'(in_ready), 32'd0);
      step();
      check_beat($sformatf("bp%0d", k), 8'h3F, 1'b0, 1'b0);
      check($sformatf("bp%0d.ch", k), 32'(out_ch), 32'd0);
    end
    out_ready = 1'b1;
    step();
    check_beat("bp.release", 8'h17, 1'b0, 1'b0);

    drive(1'b1, 2'd0, 8'h01, 1'b0, 2'd0, 2'b00, 8'h00, 1'b1);
    step();
    check("reseed.valid", 32'(out_valid), 32'd0);
    drive(1'b1, 2'd0, 8'h80, 1'b1, 2'd0, 2'b00, 8'h00, 1'b1);
    step();
    check_beat("same.old", 8'h01, 1'b0, 1'b0);
    drive(1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 2'b00, 8'h00, 1'b1);
    step();
    check_beat("same.new", 8'h80, 1'b0, 1'b0);

    drive(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 2'b00, 8'h00, 1'b0);
    rst = 1'b1;
    #2;
    check("arst.valid",  32'(out_valid), 32'd0);
    check("arst.data",   32'(out_data),  32'h0);
    check("arst.seeded", 32'(seeded),    32'h0);
    step();
    rst = 1'b0;
    drive(1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 2'b00, 8'h5A, 1'b1);
    step();
    check_beat("arst.beat", 8'h5A, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gen_gamma_stream.md
# gen_gamma_stream

Multi-channel keystream (gamma) generator and combiner, the parametrised successor to the single-channel gamma coder. Each channel owns an independently seeded Galois LFSR. Input words tagged with a channel are combined with that channel's current gamma by XOR, modular add or modular subtract. Results leave through a registered valid/ready output stage; it sits between the data source and the link framer.

## Interface
- WIDTH, 8, data/gamma word width (≥4)
- CHANNELS, 4, independent gamma channels (≥1); CH_W = max(1, $clog2(CHANNELS))
- TAPS, 8'hB8, Galois feedback mask, WIDTH bits

- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- seed_we  in  1  load seed into channel seed_ch this cycle
- seed_ch  in  CH_W  channel to seed
- seed  in  WIDTH  seed value
- in_valid  in  1  input beat present
- in_ready  out  1  block accepts beat this cycle
- in_ch  in  CH_W  channel of input beat
- in_mode  in  2  00 XOR, 01 mod-add, 10 mod-sub, 11 bypass
- in_data  in  WIDTH  plaintext/ciphertext word
- out_valid  out  1  result held
- out_ready  in  1  consumer accepts result
- out_ch  out  CH_W  channel of result
- out_data  out  WIDTH  combined word
- out_carry  out  1  carry (mod-add) or borrow (mod-sub), else 0
- out_err  out  1  beat addressed an unseeded channel
- seeded  out  CHANNELS  per-channel seeded flags

## Operation
- Accept = in_valid & in_ready; in_ready = !out_valid | out_ready (combinational).
- Gamma g = state[in_ch] before any update this cycle.
- Combine: XOR → in_data ^ g, carry 0. Mod-add → {carry,data} = in_data + g, WIDTH+1-bit sum. Mod-sub → data = (in_data − g) mod 2^WIDTH, carry = (in_data < g). Bypass → in_data, carry 0, LFSR not advanced.
- LFSR step: next = (s >> 1) ^ (s[0] ? TAPS : 0).
- On accept with seeded[in_ch]=1 and mode ≠ 11: state[in_ch] ← step(g).
- Unseeded channel: out_data = in_data, out_carry 0, out_err 1, state unchanged. The mode is ignored.
- seed_we: state[seed_ch] ← (seed == 0 ? all-ones : seed) to avoid lockup. seeded[seed_ch] ← 1.
- Simultaneous seed_we and accept on the same channel: the beat uses the old state and the old seeded flag. The seed overrides the step.
- seed_ch or in_ch ≥ CHANNELS: seed is ignored. The beat passes with out_err 1.

## Timing
- Reset: out_valid 0, out_ch 0, out_data 0, out_carry 0, out_err 0, seeded all 0, all states 0; in_ready 1 after reset deasserts.
- Latency 1: a beat accepted at edge N is on the outputs after edge N, out_valid 1.
- Full throughput: one beat/cycle while out_ready is held 1.
- Backpressure: with out_valid=1 and out_ready=0, the outputs hold stable, in_ready is 0, and no LFSR advances.
- out_valid falls after the edge where out_ready=1 and no new accept occurs.
- Reset asserted mid-stream clears the held result immediately (async). Seeds are lost.

## Structure
- Package gamma_pkg: mode enum (GM_XOR, GM_ADD, GM_SUB, GM_BYPASS), function lfsr_step(state, taps), default TAPS constant.
- Sub-module gamma_lfsr (one per channel, via generate): holds state and seeded flag. Inputs: load, seed, advance. Outputs: state and seeded.
- Top holds the channel mux, the combiner, and the output register with handshake logic.

## Test plan
- Seed ch0=8'h01; XOR beats A5, A5 on ch0 → out_data A4 then 1D; state[0] ends 8'h5C.
- Seed ch1=8'hF0; mod-add data 8'h20 → out_data 10, carry 1. Then mod-sub data 8'h10 (gamma 78) → out_data 98, carry 1.
- Beat on unseeded ch2, data 3C → out_data 3C, out_err 1, seeded[2] still 0. Seed 00 on ch2 → state FF, seeded[2] 1.
- out_ready low for 3 cycles with in_valid high → in_ready 0, outputs stable, ch0 state unchanged. Release → next beat uses the un-advanced gamma.
- Same-cycle seed ch0=8'h80 and XOR beat ch0 data 00 (state 01) → out_data 01; next beat data 00 → out_data 80.
- Assert rst while out_valid=1 → out_valid, seeded, and out_data all 0 without a clock edge. Beat after release → out_err 1.
